// File: rtl/store_unit.sv
// Byte-serial, big-endian store engine: one latched store request, one byte written per cycle.
// Define STORE_ALIGN_CHECK_EN to reject misaligned half/word requests with o_err.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [31:0]            i_data,
  input  logic [1:0]             i_size,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic [`DATA_WIDTH-1:0] o_mem_data,
  output logic                   o_mem_write
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  last_q;
  logic [31:0] shift_q;

  logic [31:0] aligned;
  logic [2:0]  last_idx;
  logic        misaligned;

  // Left-align the stored quantity so its most significant byte always sits in [31:24].
  always_comb begin
    aligned  = i_data;
    last_idx = 3'(WORD_BYTES - 1);
    case (i_size)
      2'd0: begin
        aligned  = {i_data[7:0], 24'h0};
        last_idx = 3'd0;
      end
      2'd1: begin
        aligned  = {i_data[15:0], 16'h0};
        last_idx = 3'd1;
      end
      default: begin
        aligned  = i_data;
        last_idx = 3'(WORD_BYTES - 1);
      end
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  assign misaligned = (i_size == 2'd1) ? i_addr[0] :
                      (i_size[1]       ? (i_addr[1:0] != 2'b00) : 1'b0);
`else
  assign misaligned = 1'b0;
`endif

  assign o_busy = (state_q == StWrite);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      last_q      <= 3'd0;
      shift_q     <= 32'h0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_mem_write <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          o_mem_write <= 1'b0;
          if (i_valid) begin
            if (misaligned) begin
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else begin
              // Byte 0 goes out on the accept edge itself.
              state_q     <= StWrite;
              cnt_q       <= 3'd0;
              last_q      <= last_idx;
              shift_q     <= aligned << `DATA_WIDTH;
              o_mem_addr  <= i_addr;
              o_mem_data  <= aligned[31 -: `DATA_WIDTH];
              o_mem_write <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (cnt_q == last_q) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            o_mem_write <= 1'b0;
            o_done      <= 1'b1;
          end else begin
            cnt_q       <= cnt_q + 3'd1;
            shift_q     <= shift_q << `DATA_WIDTH;
            o_mem_addr  <= o_mem_addr + ADDR_WIDTH'(1);
            o_mem_data  <= shift_q[31 -: `DATA_WIDTH];
            o_mem_write <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: stimulus queues expected writes/dones, a negedge monitor pops them.
`timescale 1ns/1ps

module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  size;
  logic        busy, done, err, mem_write;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;

  store_unit #(
    .ADDR_WIDTH(32),
    .WORD_BYTES(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_addr     (addr),
    .i_data     (data),
    .i_size     (size),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_data),
    .o_mem_write(mem_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [31:0] a;
    logic [7:0]  d;
    bit          e;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   t0     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_w(input logic [31:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.is_done = 1'b0; e.a = a; e.d = d; e.e = 1'b0; e.c = c;
    q.push_back(e);
  endtask

  task automatic push_d(input bit er, input int c);
    exp_t e;
    e.is_done = 1'b1; e.a = 32'h0; e.d = 8'h0; e.e = er; e.c = c;
    q.push_back(e);
  endtask

  // Monitor: every write strobe or done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (mem_write === 1'b1 || done === 1'b1 || err === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 32'({mem_write, done, err}), 32'h0);
      end else begin
        e = q.pop_front();
        if (e.is_done) begin
          chk("done_cycle", 32'(cyc), 32'(e.c));
          chk("done_flags", 32'({mem_write, done, err, busy}), 32'({1'b0, 1'b1, e.e, 1'b0}));
        end else begin
          chk("write_cycle", 32'(cyc), 32'(e.c));
          chk("write_addr", mem_addr, e.a);
          chk("write_data", 32'(mem_data), 32'(e.d));
          chk("write_busy", 32'({busy, done}), 32'h2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    valid = 1'b1;
    addr  = a;
    data  = d;
    size  = s;
    t0    = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ta;
    rst   = 1'b1;
    valid = 1'b0;
    addr  = 32'h0;
    data  = 32'h0;
    size  = 2'd0;
    repeat (3) tick();
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data", 32'(mem_data), 32'h0);
    chk("rst_done_err_busy", 32'({done, err, busy}), 32'h0);
    rst = 1'b0;
    tick();

    // Word, big-endian byte order
    issue(32'h100, 32'h11223344, 2'd2);
    push_w(32'h100, 8'h11, t0 + 1);
    push_w(32'h101, 8'h22, t0 + 2);
    push_w(32'h102, 8'h33, t0 + 3);
    push_w(32'h103, 8'h44, t0 + 4);
    push_d(1'b0, t0 + 5);
    tick();
    valid = 1'b0;
    drain();
    tick();
    chk("hold_mem_addr", mem_addr, 32'h103);
    chk("hold_mem_data", 32'(mem_data), 32'h44);
    chk("idle_busy", 32'(busy), 32'h0);

    // Half and byte
    issue(32'h200, 32'h0000ABCD, 2'd1);
    push_w(32'h200, 8'hAB, t0 + 1);
    push_w(32'h201, 8'hCD, t0 + 2);
    push_d(1'b0, t0 + 3);
    tick();
    valid = 1'b0;
    drain();
    issue(32'h7, 32'hFFFFFF5A, 2'd0);
    push_w(32'h7, 8'h5A, t0 + 1);
    push_d(1'b0, t0 + 2);
    tick();
    valid = 1'b0;
    drain();

    // Valid held through busy: junk presented while busy is ignored
    issue(32'h300, 32'hA1B2C3D4, 2'd2);
    ta = t0;
    push_w(32'h300, 8'hA1, ta + 1);
    push_w(32'h301, 8'hB2, ta + 2);
    push_w(32'h302, 8'hC3, ta + 3);
    push_w(32'h303, 8'hD4, ta + 4);
    push_d(1'b0, ta + 5);
    repeat (4) begin
      tick();
      addr = 32'h999;
      data = 32'hDEADBEEF;
      size = 2'd2;
    end
    tick();
    issue(32'h400, 32'h00001234, 2'd1);
    push_w(32'h400, 8'h12, ta + 6);
    push_w(32'h401, 8'h34, ta + 7);
    push_d(1'b0, ta + 8);
    tick();
    valid = 1'b0;
    drain();

    // Address wrap
    issue(32'hFFFFFFFE, 32'h0000BEEF, 2'd1);
    push_w(32'hFFFFFFFE, 8'hBE, t0 + 1);
    push_w(32'hFFFFFFFF, 8'hEF, t0 + 2);
    push_d(1'b0, t0 + 3);
    tick();
    valid = 1'b0;
    drain();
    issue(32'hFFFFFFFE, 32'hCAFEF00D, 2'd2);
`ifdef STORE_ALIGN_CHECK_EN
    push_d(1'b1, t0 + 1);
`else
    push_w(32'hFFFFFFFE, 8'hCA, t0 + 1);
    push_w(32'hFFFFFFFF, 8'hFE, t0 + 2);
    push_w(32'h00000000, 8'hF0, t0 + 3);
    push_w(32'h00000001, 8'h0D, t0 + 4);
    push_d(1'b0, t0 + 5);
`endif
    tick();
    valid = 1'b0;
    drain();

    // Reset in the middle of a word store
    issue(32'h500, 32'h55667788, 2'd2);
    push_w(32'h500, 8'h55, t0 + 1);
    push_w(32'h501, 8'h66, t0 + 2);
    tick();
    valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_mem_write", 32'(mem_write), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    repeat (6) tick();
    drain();
    issue(32'h10, 32'h00000077, 2'd0);
    push_w(32'h10, 8'h77, t0 + 1);
    push_d(1'b0, t0 + 2);
    tick();
    valid = 1'b0;
    drain();

    // Misaligned word
    issue(32'h102, 32'h01020304, 2'd2);
`ifdef STORE_ALIGN_CHECK_EN
    push_d(1'b1, t0 + 1);
`else
    push_w(32'h102, 8'h01, t0 + 1);
    push_w(32'h103, 8'h02, t0 + 2);
    push_w(32'h104, 8'h03, t0 + 3);
    push_w(32'h105, 8'h04, t0 + 4);
    push_d(1'b0, t0 + 5);
`endif
    tick();
    valid = 1'b0;
    drain();

    repeat (4) tick();
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
